// File: rtl/csr_spmv_engine.sv
// csr_spmv_engine
//
// Sparse matrix x spike-vector engine. Walks a ROWS x COLS matrix held in
// CSR form and, for every row, accumulates the non-zero values whose column
// is set in a latched spike vector. Accumulation saturates (unsigned or two's
// complement, chosen by SIGNED). Rows are processed one after another and
// each result is written when its row is finished.
//
// Ports:
//   clk          clock, rising edge
//   rst          asynchronous, active-high reset
//   start        run request, sampled only while idle
//   spike_train  COLS-bit spike vector, bit c = column c (latched at start)
//   row_ptr      (ROWS+1) CSR row pointers, PTR_W bits each
//   values       NNZ matrix values, VAL_W bits each
//   col_idx      NNZ column indices, CIX_W bits each
//   result       ROWS accumulated sums, ACC_W bits each
//   busy         run in progress (first accumulate setup through DONE)
//   done         one-cycle pulse after the last row has been written
module csr_spmv_engine #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int NNZ    = 16,
    parameter int VAL_W  = 16,
    parameter int ACC_W  = 16,
    parameter int SIGNED = 0,
    localparam int PTR_W = $clog2(NNZ + 1),
    localparam int CIX_W = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [COLS-1:0]             spike_train,
    input  logic [(ROWS+1)*PTR_W-1:0]   row_ptr,
    input  logic [NNZ*VAL_W-1:0]        values,
    input  logic [NNZ*CIX_W-1:0]        col_idx,
    output logic [ROWS*ACC_W-1:0]       result,
    output logic                        busy,
    output logic                        done
);

    localparam int R_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    // Spike vector padded to every encodable column index; the padding bits
    // are zero so out-of-range columns contribute nothing.
    localparam int SPK_W = 1 << CIX_W;
    localparam logic [ACC_W-1:0] SMIN = ACC_W'(1) << (ACC_W - 1);
    localparam logic [ACC_W-1:0] SMAX = ~SMIN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCUM,
        S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [COLS-1:0]         spk_q, spk_d;
    logic [R_W-1:0]          r_q, r_d;
    logic [PTR_W-1:0]        k_q, k_d;
    logic [PTR_W-1:0]        end_q, end_d;
    logic [ACC_W-1:0]        acc_q, acc_d;
    logic [ROWS*ACC_W-1:0]   result_q, result_d;
    logic                    busy_q, busy_d;

    // Saturating add of one term to the accumulator. Both operands are
    // extended by one bit so the carry/overflow is visible in sum[ACC_W].
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [VAL_W-1:0] t);
        logic                  sx_a;
        logic                  sx_t;
        logic signed [ACC_W:0] sum;
        sx_a = (SIGNED != 0) && a[ACC_W-1];
        sx_t = (SIGNED != 0) && t[VAL_W-1];
        sum  = $signed({sx_a, a}) + $signed({{(ACC_W + 1 - VAL_W){sx_t}}, t});
        if (SIGNED != 0) begin
            if (sum[ACC_W] != sum[ACC_W-1]) sat_add = sum[ACC_W] ? SMIN : SMAX;
            else                            sat_add = sum[ACC_W-1:0];
        end else begin
            sat_add = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
        end
    endfunction

    logic [PTR_W-1:0] ptr_lo;
    logic [PTR_W-1:0] ptr_hi;
    logic             k_live;
    int               k_ix;
    logic [CIX_W-1:0] col;
    logic [VAL_W-1:0] val;
    logic [SPK_W-1:0] spk_ext;
    logic [VAL_W-1:0] term;

    assign ptr_lo  = row_ptr[int'(r_q) * PTR_W +: PTR_W];
    assign ptr_hi  = row_ptr[(int'(r_q) + 1) * PTR_W +: PTR_W];
    // An entry is consumed only while inside the row and inside the arrays.
    assign k_live  = (k_q < end_q) && (k_q < PTR_W'(NNZ));
    // Keep the array lookups in range even when k has run past NNZ.
    assign k_ix    = k_live ? int'(k_q) : 0;
    assign col     = col_idx[k_ix * CIX_W +: CIX_W];
    assign val     = values[k_ix * VAL_W +: VAL_W];
    assign spk_ext = SPK_W'(spk_q);
    assign term    = spk_ext[col] ? val : '0;

    always_comb begin
        state_q_to_d: begin
            state_d  = state_q;
            spk_d    = spk_q;
            r_d      = r_q;
            k_d      = k_q;
            end_d    = end_q;
            acc_d    = acc_q;
            result_d = result_q;
            busy_d   = busy_q;
        end
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    spk_d   = spike_train;
                    r_d     = '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                k_d     = ptr_lo;
                end_d   = ptr_hi;
                acc_d   = '0;
                busy_d  = 1'b1;
                state_d = S_ACCUM;
            end
            S_ACCUM: begin
                if (k_live) begin
                    acc_d = sat_add(acc_q, term);
                    k_d   = k_q + PTR_W'(1);
                end else begin
                    result_d[int'(r_q) * ACC_W +: ACC_W] = acc_q;
                    if (r_q == R_W'(ROWS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        r_d     = r_q + R_W'(1);
                        state_d = S_SETUP;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            spk_q    <= '0;
            r_q      <= '0;
            k_q      <= '0;
            end_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            spk_q    <= spk_d;
            r_q      <= r_d;
            k_q      <= k_d;
            end_q    <= end_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = (state_q == S_DONE);

endmodule

// File: tb/tb_csr_spmv_engine.sv
module tb_csr_spmv_engine;

    localparam int ROWS  = 4;
    localparam int NNZ   = 16;
    localparam int VAL_W = 16;
    localparam int ACC_W = 16;
    localparam int PTR_W = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                      start_a, start_b;
    logic [3:0]                spike_a;
    logic [4:0]                spike_b;
    logic [(ROWS+1)*PTR_W-1:0] row_ptr;
    logic [NNZ*VAL_W-1:0]      values;
    logic [NNZ*2-1:0]          col_a;
    logic [NNZ*3-1:0]          col_b;
    logic [ROWS*ACC_W-1:0]     result_a, result_b;
    logic                      busy_a, done_a, busy_b, done_b;

    // Unsigned 4x4 engine.
    csr_spmv_engine #(.ROWS(4), .COLS(4), .NNZ(16), .VAL_W(16), .ACC_W(16), .SIGNED(0)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .spike_train(spike_a),
        .row_ptr(row_ptr), .values(values), .col_idx(col_a),
        .result(result_a), .busy(busy_a), .done(done_a));

    // Signed engine with 5 columns: 3-bit column indices can name 5..7.
    csr_spmv_engine #(.ROWS(4), .COLS(5), .NNZ(16), .VAL_W(16), .ACC_W(16), .SIGNED(1)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .spike_train(spike_b),
        .row_ptr(row_ptr), .values(values), .col_idx(col_b),
        .result(result_b), .busy(busy_b), .done(done_b));

    int m_ptr[ROWS+1];
    int m_val[NNZ];
    int m_col[NNZ];
    int errs   = 0;
    int checks = 0;

    task automatic pack();
        for (int i = 0; i <= ROWS; i++) row_ptr[i*PTR_W +: PTR_W] = PTR_W'(m_ptr[i]);
        for (int k = 0; k < NNZ; k++) begin
            values[k*VAL_W +: VAL_W] = 16'(m_val[k]);
            col_a[k*2 +: 2]          = 2'(m_col[k]);
            col_b[k*3 +: 3]          = 3'(m_col[k]);
        end
    endtask

    task automatic fill_random(input int maxcol);
        m_ptr[0] = $urandom_range(0, 3);
        for (int i = 1; i <= ROWS; i++) m_ptr[i] = m_ptr[i-1] + $urandom_range(0, 6);
        if ($urandom_range(0, 3) == 0) m_ptr[$urandom_range(1, ROWS)] = $urandom_range(0, 4);
        for (int k = 0; k < NNZ; k++) begin
            m_val[k] = $urandom_range(0, 65535);
            m_col[k] = $urandom_range(0, maxcol);
        end
        pack();
    endtask

    // Reference: integer sum of spiking entries, clamped after every add.
    function automatic logic [15:0] model_row(input int r, input int cols, input bit sgn,
                                              input logic [4:0] spk);
        longint acc, v, mx, mn;
        acc = 0;
        mx  = sgn ? 32767 : 65535;
        mn  = sgn ? -32768 : 0;
        for (int k = m_ptr[r]; k < m_ptr[r+1] && k < NNZ; k++) begin
            if (m_col[k] < cols && spk[m_col[k]]) begin
                v = longint'(m_val[k] & 32'hFFFF);
                if (sgn && v >= 32768) v = v - 65536;
                acc = acc + v;
                if (acc > mx) acc = mx;
                if (acc < mn) acc = mn;
            end
        end
        return 16'(acc);
    endfunction

    // Cycles from the accepting edge to done: two per row plus every entry visited.
    function automatic int model_lat();
        int n, hi;
        n = 0;
        for (int r = 0; r < ROWS; r++) begin
            hi = (m_ptr[r+1] < NNZ) ? m_ptr[r+1] : NNZ;
            if (hi > m_ptr[r]) n += hi - m_ptr[r];
        end
        return 2 * ROWS + n;
    endfunction

    function automatic logic [15:0] res(input bit sel, input int r);
        return sel ? result_b[r*ACC_W +: ACC_W] : result_a[r*ACC_W +: ACC_W];
    endfunction

    // Pulse start, scramble the spike input right after acceptance, then count
    // cycles to done (bounded) and busy-high cycles; tail = busy|done one cycle later.
    task automatic run_dut(input bit sel, input logic [4:0] spk,
                           output int lat, output int bcnt, output logic tail);
        @(negedge clk);
        if (sel) begin start_b = 1'b1; spike_b = spk; end
        else     begin start_a = 1'b1; spike_a = spk[3:0]; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
        spike_a = 4'($urandom); spike_b = 5'($urandom);
        lat = 0; bcnt = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (sel ? busy_b : busy_a) bcnt++;
        end while (!(sel ? done_b : done_a) && lat < 300);
        @(posedge clk); #1;
        tail = sel ? (busy_b | done_b) : (busy_a | done_a);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; spike_a = '0; spike_b = '0;
        for (int i = 0; i <= ROWS; i++) m_ptr[i] = 0;
        for (int k = 0; k < NNZ; k++) begin m_val[k] = 0; m_col[k] = 0; end
        pack();
        #12;
        checks++; if (result_a !== '0) begin errs++; $display("FAIL reset result_a: got %h want 0", result_a); end
        checks++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin errs++; $display("FAIL reset ctl_a: busy=%b done=%b want 0 0", busy_a, done_a); end
        checks++; if (result_b !== '0) begin errs++; $display("FAIL reset result_b: got %h want 0", result_b); end
        checks++; if (busy_b !== 1'b0 || done_b !== 1'b0) begin errs++; $display("FAIL reset ctl_b: busy=%b done=%b want 0 0", busy_b, done_b); end
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_dense();
        int lat, bcnt; logic tail;
        logic [15:0] want[4];
        want = '{16'd4, 16'd12, 16'd20, 16'd28};
        for (int i = 0; i <= ROWS; i++) m_ptr[i] = 4 * i;
        for (int k = 0; k < NNZ; k++) begin m_val[k] = k + 1; m_col[k] = k % 4; end
        pack();
        run_dut(1'b0, 5'b00101, lat, bcnt, tail);
        checks++; if (lat !== 24) begin errs++; $display("FAIL dense latency: got %0d want 24", lat); end
        checks++; if (bcnt !== 24) begin errs++; $display("FAIL dense busy cycles: got %0d want 24", bcnt); end
        checks++; if (tail !== 1'b0) begin errs++; $display("FAIL dense done pulse: busy|done=%b after done, want 0", tail); end
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (res(1'b0, r) !== want[r]) begin errs++; $display("FAIL dense row%0d: got %0d want %0d", r, res(1'b0, r), want[r]); end
        end
    endtask

    task automatic test_empty_rows();
        int lat, bcnt; logic tail; logic [4:0] spk;
        fill_random(3);
        m_ptr = '{0, 0, 2, 2, 3};
        pack();
        spk = 5'($urandom);
        run_dut(1'b0, spk, lat, bcnt, tail);
        checks++; if (lat !== 11) begin errs++; $display("FAIL empty latency: got %0d want 11", lat); end
        checks++; if (res(1'b0, 0) !== 16'd0 || res(1'b0, 2) !== 16'd0) begin
            errs++; $display("FAIL empty rows0/2: got %h %h want 0 0", res(1'b0, 0), res(1'b0, 2)); end
        for (int r = 1; r < ROWS; r += 2) begin
            checks++;
            if (res(1'b0, r) !== model_row(r, 4, 1'b0, spk)) begin
                errs++; $display("FAIL empty row%0d: got %h want %h", r, res(1'b0, r), model_row(r, 4, 1'b0, spk)); end
        end
    endtask

    task automatic test_saturation();
        int lat, bcnt; logic tail;
        m_ptr = '{0, 4, 4, 4, 4};
        for (int k = 0; k < NNZ; k++) begin m_val[k] = (k < 4) ? 32'hF000 : 0; m_col[k] = k % 4; end
        pack();
        run_dut(1'b0, 5'b01111, lat, bcnt, tail);
        checks++; if (res(1'b0, 0) !== 16'hFFFF) begin errs++; $display("FAIL sat unsigned: got %h want FFFF", res(1'b0, 0)); end
        checks++; if (lat !== 12) begin errs++; $display("FAIL sat latency: got %0d want 12", lat); end
        for (int k = 0; k < 4; k++) m_val[k] = 32'h9000;
        pack();
        run_dut(1'b1, 5'b11111, lat, bcnt, tail);
        checks++; if (res(1'b1, 0) !== 16'h8000) begin errs++; $display("FAIL sat signed: got %h want 8000", res(1'b1, 0)); end
        for (int k = 0; k < 4; k++) m_val[k] = 32'h7000;
        pack();
        run_dut(1'b1, 5'b11111, lat, bcnt, tail);
        checks++; if (res(1'b1, 0) !== 16'h7FFF) begin errs++; $display("FAIL sat signed pos: got %h want 7FFF", res(1'b1, 0)); end
    endtask

    task automatic test_invalid_col();
        int lat, bcnt; logic tail;
        fill_random(4);
        m_ptr = '{0, 3, 6, 8, 10};
        m_col[0] = 5; m_col[1] = 6; m_col[2] = 7; m_col[3] = 7; m_col[4] = 0;
        pack();
        run_dut(1'b1, 5'b11111, lat, bcnt, tail);
        checks++; if (res(1'b1, 0) !== 16'd0) begin errs++; $display("FAIL invalid col row0: got %h want 0", res(1'b1, 0)); end
        for (int r = 1; r < ROWS; r++) begin
            checks++;
            if (res(1'b1, r) !== model_row(r, 5, 1'b1, 5'b11111)) begin
                errs++; $display("FAIL invalid col row%0d: got %h want %h", r, res(1'b1, r), model_row(r, 5, 1'b1, 5'b11111)); end
        end
        checks++; if (lat !== model_lat()) begin errs++; $display("FAIL invalid col latency: got %0d want %0d", lat, model_lat()); end
    endtask

    task automatic test_random();
        int lat, bcnt; logic tail; logic [4:0] spk; bit sel;
        for (int it = 0; it < 24; it++) begin
            sel = it[0];
            fill_random(sel ? 7 : 3);
            spk = 5'($urandom);
            if (!sel) spk[4] = 1'b0;
            run_dut(sel, spk, lat, bcnt, tail);
            checks++; if (lat !== model_lat() || bcnt !== model_lat()) begin
                errs++; $display("FAIL random%0d timing: lat=%0d busy=%0d want %0d", it, lat, bcnt, model_lat()); end
            for (int r = 0; r < ROWS; r++) begin
                checks++;
                if (res(sel, r) !== model_row(r, sel ? 5 : 4, sel, spk)) begin
                    errs++; $display("FAIL random%0d row%0d: got %h want %h", it, r, res(sel, r), model_row(r, sel ? 5 : 4, sel, spk)); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int l1, l2, lw;
        fill_random(3);
        lw = model_lat();
        @(negedge clk);
        spike_a = 4'b1011; start_a = 1'b1;
        @(posedge clk); #1;
        l1 = 0;
        do begin @(posedge clk); #1; l1++; end while (!done_a && l1 < 300);
        l2 = 0;
        do begin @(posedge clk); #1; l2++; end while (!done_a && l2 < 300);
        start_a = 1'b0;
        checks++; if (l1 !== lw) begin errs++; $display("FAIL b2b first run: got %0d want %0d", l1, lw); end
        checks++; if (l2 !== lw + 2) begin errs++; $display("FAIL b2b restart gap: got %0d want %0d", l2, lw + 2); end
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (res(1'b0, r) !== model_row(r, 4, 1'b0, 5'b01011)) begin
                errs++; $display("FAIL b2b row%0d: got %h want %h", r, res(1'b0, r), model_row(r, 4, 1'b0, 5'b01011)); end
        end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy_a !== 1'b0) begin errs++; $display("FAIL b2b idle after release: busy=%b want 0", busy_a); end
    endtask

    task automatic test_reset_mid();
        int lat, bcnt; logic tail;
        for (int i = 0; i <= ROWS; i++) m_ptr[i] = 4 * i;
        for (int k = 0; k < NNZ; k++) begin m_val[k] = k + 1; m_col[k] = k % 4; end
        pack();
        run_dut(1'b0, 5'b01111, lat, bcnt, tail);
        checks++; if (res(1'b0, 3) !== 16'd58) begin errs++; $display("FAIL pre-reset row3: got %0d want 58", res(1'b0, 3)); end
        @(negedge clk); start_a = 1'b1; spike_a = 4'b1111;
        @(posedge clk); #1; start_a = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (result_a !== '0 || busy_a !== 1'b0 || done_a !== 1'b0) begin
            errs++; $display("FAIL mid reset: result=%h busy=%b done=%b want 0", result_a, busy_a, done_a); end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        run_dut(1'b0, 5'b00110, lat, bcnt, tail);
        checks++; if (lat !== 24) begin errs++; $display("FAIL post reset latency: got %0d want 24", lat); end
        for (int r = 0; r < ROWS; r++) begin
            checks++;
            if (res(1'b0, r) !== model_row(r, 4, 1'b0, 5'b00110)) begin
                errs++; $display("FAIL post reset row%0d: got %h want %h", r, res(1'b0, r), model_row(r, 4, 1'b0, 5'b00110)); end
        end
    endtask

    initial begin
        test_reset();
        test_dense();
        test_empty_rows();
        test_saturation();
        test_invalid_col();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
